// File: rtl/bpu_update_ctrl_if.sv
// Handshake and status bundle between fetch/EXE and the gshare update controller.
interface bpu_update_ctrl_if #(
  parameter int unsigned GHR_BITS = 8
);
  logic [31:0]         fetch_pc;
  logic [GHR_BITS-1:0] lookup_index;
  logic                pred_valid;
  logic                pred_taken;
  logic                pred_ready;
  logic                res_valid;
  logic                res_taken;
  logic                res_ready;
  logic                ext_flush;
  logic                upd_valid;
  logic [GHR_BITS-1:0] upd_index;
  logic                upd_taken;
  logic                mispredict;
  logic                init_valid;
  logic [GHR_BITS-1:0] init_index;
  logic [GHR_BITS-1:0] ghr_spec;

  modport master (
    output fetch_pc, pred_valid, pred_taken, res_valid, res_taken, ext_flush,
    input  lookup_index, pred_ready, res_ready, upd_valid, upd_index, upd_taken,
           mispredict, init_valid, init_index, ghr_spec
  );

  modport slave (
    input  fetch_pc, pred_valid, pred_taken, res_valid, res_taken, ext_flush,
    output lookup_index, pred_ready, res_ready, upd_valid, upd_index, upd_taken,
           mispredict, init_valid, init_index, ghr_spec
  );
endinterface

// File: rtl/bpu_update_ctrl.sv
// gshare sequencing controller: BHT init sweep, in-order prediction queue,
// counter-update issue and speculative/architectural history repair.
module bpu_update_ctrl #(
  parameter int unsigned GHR_BITS = 8,
  parameter int unsigned BHT_SIZE = 256,
  parameter int unsigned DEPTH    = 4
) (
  input logic             clk,
  input logic             reset,
  bpu_update_ctrl_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [GHR_BITS-1:0] init_cnt_q, init_cnt_d;
  logic [GHR_BITS-1:0] ghr_spec_q, ghr_spec_d;
  logic [GHR_BITS-1:0] ghr_arch_q, ghr_arch_d;
  logic [GHR_BITS-1:0] upd_index_q, upd_index_d;
  logic                upd_valid_q, upd_valid_d;
  logic                upd_taken_q, upd_taken_d;
  logic                mispredict_q, mispredict_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic [GHR_BITS-1:0] idx_mem [DEPTH];
  logic [DEPTH-1:0]    tkn_mem;

  logic [GHR_BITS-1:0] lookup;
  logic                pred_ready, res_ready;
  logic                push, pop, mis, flush;
  logic                unused_pc;

  assign lookup     = bus.fetch_pc[GHR_BITS+1:2] ^ ghr_spec_q;
  assign unused_pc  = ^{bus.fetch_pc[31:GHR_BITS+2], bus.fetch_pc[1:0]};
  assign pred_ready = (state_q == RUN) && (count_q < CW'(DEPTH));
  assign res_ready  = (state_q == RUN) && (count_q != '0);
  assign push       = bus.pred_valid & pred_ready;
  assign pop        = bus.res_valid & res_ready;
  assign mis        = pop & (bus.res_taken != tkn_mem[rd_ptr_q]);
  assign flush      = mis | ((state_q == RUN) & bus.ext_flush);

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    ghr_spec_d   = ghr_spec_q;
    ghr_arch_d   = ghr_arch_q;
    upd_valid_d  = 1'b0;
    upd_index_d  = upd_index_q;
    upd_taken_d  = upd_taken_q;
    mispredict_d = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == GHR_BITS'(BHT_SIZE - 1)) state_d = RUN;
      end
      RUN: begin
        if (pop) begin
          ghr_arch_d   = {ghr_arch_q[GHR_BITS-2:0], bus.res_taken};
          upd_valid_d  = 1'b1;
          upd_index_d  = idx_mem[rd_ptr_q];
          upd_taken_d  = bus.res_taken;
          mispredict_d = mis;
          rd_ptr_d     = rd_ptr_q + 1'b1;
        end
        if (push) begin
          wr_ptr_d   = wr_ptr_q + 1'b1;
          ghr_spec_d = {ghr_spec_q[GHR_BITS-2:0], bus.pred_taken};
        end
        count_d = count_q + CW'(push) - CW'(pop);
        // Both flush causes repair from the post-pop architectural history,
        // which for a mispredict already contains the corrected direction.
        if (flush) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          ghr_spec_d = ghr_arch_d;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      ghr_spec_q   <= '0;
      ghr_arch_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_index_q  <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      ghr_spec_q   <= ghr_spec_d;
      ghr_arch_q   <= ghr_arch_d;
      upd_valid_q  <= upd_valid_d;
      upd_index_q  <= upd_index_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      idx_mem[wr_ptr_q] <= lookup;
      tkn_mem[wr_ptr_q] <= bus.pred_taken;
    end
  end

  assign bus.lookup_index = lookup;
  assign bus.pred_ready   = pred_ready;
  assign bus.res_ready    = res_ready;
  assign bus.upd_valid    = upd_valid_q;
  assign bus.upd_index    = upd_index_q;
  assign bus.upd_taken    = upd_taken_q;
  assign bus.mispredict   = mispredict_q;
  assign bus.init_valid   = (state_q == INIT);
  assign bus.init_index   = init_cnt_q;
  assign bus.ghr_spec     = ghr_spec_q;
endmodule
